// File: rtl/txn_ctrl_pkg.sv
// Shared types for the multi-channel transaction controller.
package txn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        ABORT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_KILL  = 2'd0,
        ERR_PROTO = 2'd1,
        ERR_OVF   = 2'd2,
        ERR_TMO   = 2'd3
    } err_e;

endpackage

// File: rtl/txn_ctrl_mc_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping.
module rr_arb #(
    parameter int NCH   = 4,
    parameter int OWN_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]   req_i,
    input  logic [OWN_W-1:0] ptr_i,
    output logic [NCH-1:0]   gnt_o,
    output logic [OWN_W-1:0] idx_o
);

    logic             found;
    logic [OWN_W-1:0] sel;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NCH; i++) begin
            sel = OWN_W'((int'(ptr_i) + i) % NCH);
            if (!found && req_i[sel]) begin
                found      = 1'b1;
                gnt_o[sel] = 1'b1;
                idx_o      = sel;
            end
        end
    end

endmodule

// File: rtl/txn_ctrl_mc.sv
// Round-robin multi-channel transaction controller: one transaction at a time on a
// shared get/put port, with direction lock, beat limit, idle timeout and abort reporting.
module txn_ctrl_mc
    import txn_ctrl_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int MAX_BEATS = 16,
    parameter int TIMEOUT   = 8,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1),
    parameter int OWN_W     = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   go,
    input  logic [NCH-1:0]   kill,
    input  logic             get,
    input  logic             put,
    input  logic             endtx,
    output logic [NCH-1:0]   gnt,
    output logic [OWN_W-1:0] owner,
    output logic             busy,
    output logic             dir_wr,
    output logic [CNT_W-1:0] beats,
    output logic             done,
    output logic             abort,
    output logic [1:0]       err,
    output state_e           dbg_state
);

    localparam int               TMR_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] BEATS_MAX = CNT_W'(MAX_BEATS);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [OWN_W-1:0] OWN_LAST  = OWN_W'(NCH - 1);

    state_e           state_q, state_d;
    logic [NCH-1:0]   gnt_q, gnt_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             dir_wr_q, dir_wr_d;
    logic             dir_lock_q, dir_lock_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    err_e             err_q, err_d;

    logic [NCH-1:0]   arb_gnt;
    logic [OWN_W-1:0] arb_idx;
    logic             beat;
    logic             both;

    rr_arb #(
        .NCH   (NCH),
        .OWN_W (OWN_W)
    ) u_arb (
        .req_i (go),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign beat = get | put;
    assign both = get & put;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        dir_wr_d   = dir_wr_q;
        dir_lock_d = dir_lock_q;
        beats_d    = beats_q;
        timer_d    = timer_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                gnt_d      = '0;
                owner_d    = '0;
                busy_d     = 1'b0;
                dir_wr_d   = 1'b0;
                dir_lock_d = 1'b0;
                beats_d    = '0;
                timer_d    = '0;
                err_d      = ERR_KILL;
                if (|go) begin
                    state_d = ACTIVE;
                    gnt_d   = arb_gnt;
                    owner_d = arb_idx;
                    busy_d  = 1'b1;
                end
            end
            ACTIVE: begin
                // Abort causes are checked strictly before completion or counting.
                if (kill[owner_q]) begin
                    state_d = ABORT;
                    abort_d = 1'b1;
                    err_d   = ERR_KILL;
                end else if (both || (beat && dir_lock_q && (put != dir_wr_q))) begin
                    state_d = ABORT;
                    abort_d = 1'b1;
                    err_d   = ERR_PROTO;
                end else if (beat && (beats_q == BEATS_MAX)) begin
                    state_d = ABORT;
                    abort_d = 1'b1;
                    err_d   = ERR_OVF;
                end else begin
                    if (beat) begin
                        beats_d    = beats_q + 1'b1;
                        timer_d    = '0;
                        dir_lock_d = 1'b1;
                        dir_wr_d   = put;
                    end
                    if (endtx) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (!beat) begin
                        if (timer_q == TMR_LAST) begin
                            state_d = ABORT;
                            abort_d = 1'b1;
                            err_d   = ERR_TMO;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
            end
            DONE, ABORT: begin
                state_d    = IDLE;
                ptr_d      = (owner_q == OWN_LAST) ? '0 : owner_q + 1'b1;
                gnt_d      = '0;
                owner_d    = '0;
                busy_d     = 1'b0;
                dir_wr_d   = 1'b0;
                dir_lock_d = 1'b0;
                beats_d    = '0;
                timer_d    = '0;
                err_d      = ERR_KILL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            dir_wr_q   <= 1'b0;
            dir_lock_q <= 1'b0;
            beats_q    <= '0;
            timer_q    <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            err_q      <= ERR_KILL;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            dir_wr_q   <= dir_wr_d;
            dir_lock_q <= dir_lock_d;
            beats_q    <= beats_d;
            timer_q    <= timer_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            err_q      <= err_d;
        end
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign dir_wr    = dir_wr_q;
    assign beats     = beats_q;
    assign done      = done_q;
    assign abort     = abort_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_txn_ctrl_mc.sv
// Bench for txn_ctrl_mc: a directed vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_txn_ctrl_mc;
    import txn_ctrl_pkg::*;

    localparam int NCH       = 4;
    localparam int MAX_BEATS = 16;
    localparam int TIMEOUT   = 8;
    localparam int CNT_W     = 5;
    localparam int OWN_W     = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   go;
    logic [NCH-1:0]   kill;
    logic             get;
    logic             put;
    logic             endtx;
    logic [NCH-1:0]   gnt;
    logic [OWN_W-1:0] owner;
    logic             busy;
    logic             dir_wr;
    logic [CNT_W-1:0] beats;
    logic             done;
    logic             abort;
    logic [1:0]       err;
    state_e           dbg_state;

    txn_ctrl_mc #(
        .NCH       (NCH),
        .MAX_BEATS (MAX_BEATS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .kill      (kill),
        .get       (get),
        .put       (put),
        .endtx     (endtx),
        .gnt       (gnt),
        .owner     (owner),
        .busy      (busy),
        .dir_wr    (dir_wr),
        .beats     (beats),
        .done      (done),
        .abort     (abort),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0]   gnt;
        logic [OWN_W-1:0] owner;
        logic             busy;
        logic             dir_wr;
        logic [CNT_W-1:0] beats;
        logic             done;
        logic             abort;
        logic [1:0]       err;
    } out_t;

    typedef struct {
        logic [NCH-1:0] go;
        logic [NCH-1:0] kill;
        logic           get;
        logic           put;
        logic           endtx;
        out_t           exp;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: transaction-level view (who owns the port, how many beats,
    // how long since the last beat, and whether this is the closing cycle).
    bit m_act;
    int m_end;   // 0 running, 1 completing, 2 aborting
    int m_owner;
    int m_cnt;
    int m_idle;
    int m_dir;   // -1 unlocked, 0 get, 1 put
    int m_ptr;
    int m_err;

    function automatic out_t mk_out(input logic [NCH-1:0] g, input int o, input logic b,
                                    input logic d, input int bt, input logic dn,
                                    input logic ab, input int e);
        out_t r;
        r.gnt    = g;
        r.owner  = OWN_W'(o);
        r.busy   = b;
        r.dir_wr = d;
        r.beats  = CNT_W'(bt);
        r.done   = dn;
        r.abort  = ab;
        r.err    = 2'(e);
        return r;
    endfunction

    function automatic vec_t mk_vec(input logic [NCH-1:0] g, input logic [NCH-1:0] k,
                                    input logic gt, input logic pt, input logic et,
                                    input out_t e);
        vec_t v;
        v.go    = g;
        v.kill  = k;
        v.get   = gt;
        v.put   = pt;
        v.endtx = et;
        v.exp   = e;
        return v;
    endfunction

    function automatic out_t model_out();
        out_t r;
        r = '0;
        if (m_act) begin
            r.gnt    = NCH'(1) << m_owner;
            r.owner  = OWN_W'(m_owner);
            r.busy   = 1'b1;
            r.dir_wr = (m_dir == 1);
            r.beats  = CNT_W'(m_cnt);
            r.done   = (m_end == 1);
            r.abort  = (m_end == 2);
            r.err    = (m_end == 2) ? 2'(m_err) : 2'd0;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_act = 0; m_end = 0; m_owner = 0; m_cnt = 0;
        m_idle = 0; m_dir = -1; m_ptr = 0; m_err = 0;
    endtask

    task automatic model_abort(input int cause);
        m_end = 2;
        m_err = cause;
    endtask

    task automatic model_step(input logic [NCH-1:0] g, input logic [NCH-1:0] k,
                              input logic gt, input logic pt, input logic et, input logic r);
        int nb;
        bit found;
        if (r) begin
            model_reset();
        end else if (m_end != 0) begin
            m_ptr = (m_owner + 1) % NCH;
            m_end = 0;
            m_act = 0;
        end else if (!m_act) begin
            found = 0;
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (m_ptr + i) % NCH;
                if (!found && g[c]) begin
                    found   = 1;
                    m_owner = c;
                end
            end
            if (found) begin
                m_act = 1; m_cnt = 0; m_idle = 0; m_dir = -1;
            end
        end else begin
            nb = int'(gt) + int'(pt);
            if (k[m_owner]) model_abort(0);
            else if (nb == 2 || (nb == 1 && m_dir != -1 && m_dir != int'(pt))) model_abort(1);
            else if (nb == 1 && m_cnt == MAX_BEATS) model_abort(2);
            else begin
                if (nb == 1) begin
                    m_cnt  = m_cnt + 1;
                    m_idle = 0;
                    m_dir  = int'(pt);
                end
                if (et) m_end = 1;
                else if (nb == 0) begin
                    m_idle = m_idle + 1;
                    if (m_idle == TIMEOUT) model_abort(3);
                end
            end
        end
    endtask

    task automatic step(input logic [NCH-1:0] g, input logic [NCH-1:0] k,
                        input logic gt, input logic pt, input logic et, input logic r);
        go = g; kill = k; get = gt; put = pt; endtx = et; rst = r;
        @(posedge clk);
        model_step(g, k, gt, pt, et, r);
        #1;
    endtask

    // Outside a transaction only gnt/busy/pulses are defined; dir_wr only once locked;
    // err only alongside abort. A full check (after reset) covers everything.
    task automatic check(input string name, input out_t exp, input bit full);
        out_t act;
        bit   bad;
        act.gnt = gnt; act.owner = owner; act.busy = busy; act.dir_wr = dir_wr;
        act.beats = beats; act.done = done; act.abort = abort; act.err = err;
        bad = (act.gnt != exp.gnt) || (act.busy != exp.busy) ||
              (act.done != exp.done) || (act.abort != exp.abort);
        if (full || exp.busy)
            bad = bad || (act.owner != exp.owner) || (act.beats != exp.beats);
        if (full || (exp.busy && exp.beats != 0))
            bad = bad || (act.dir_wr != exp.dir_wr);
        if (full || exp.abort)
            bad = bad || (act.err != exp.err);
        if (full)
            bad = bad || (dbg_state != IDLE);
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL %s: got gnt=%b owner=%0d busy=%b dir_wr=%b beats=%0d done=%b abort=%b err=%0d state=%0d, want gnt=%b owner=%0d busy=%b dir_wr=%b beats=%0d done=%b abort=%b err=%0d",
                     name, act.gnt, act.owner, act.busy, act.dir_wr, act.beats, act.done,
                     act.abort, act.err, dbg_state, exp.gnt, exp.owner, exp.busy, exp.dir_wr,
                     exp.beats, exp.done, exp.abort, exp.err);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step_chk(input string name, input logic [NCH-1:0] g,
                            input logic [NCH-1:0] k, input logic gt, input logic pt,
                            input logic et);
        step(g, k, gt, pt, et, 1'b0);
        check(name, model_out(), 1'b0);
    endtask

    vec_t vecs[17];
    out_t z;

    initial begin
        logic [NCH-1:0] rg, rk;
        logic           rgt, rpt, ret, rr;
        int             sel;
        bit             rdir;

        z = '0;
        model_reset();
        step('0, '0, 0, 0, 0, 1'b1);
        step('0, '0, 0, 0, 0, 1'b1);
        check("reset", z, 1'b1);

        // go gnt owner busy dir beats done abort err
        vecs[0]  = mk_vec(4'b0010, 4'b0000, 0, 0, 0, mk_out(4'b0010, 1, 1, 0, 0, 0, 0, 0));
        vecs[1]  = mk_vec(4'b0000, 4'b0000, 0, 1, 0, mk_out(4'b0010, 1, 1, 1, 1, 0, 0, 0));
        vecs[2]  = mk_vec(4'b0000, 4'b0000, 0, 1, 0, mk_out(4'b0010, 1, 1, 1, 2, 0, 0, 0));
        vecs[3]  = mk_vec(4'b0000, 4'b0000, 0, 1, 0, mk_out(4'b0010, 1, 1, 1, 3, 0, 0, 0));
        vecs[4]  = mk_vec(4'b0000, 4'b0000, 0, 0, 1, mk_out(4'b0010, 1, 1, 1, 3, 1, 0, 0));
        vecs[5]  = mk_vec(4'b0000, 4'b0000, 0, 0, 0, z);
        vecs[6]  = mk_vec(4'b0100, 4'b0000, 0, 0, 0, mk_out(4'b0100, 2, 1, 0, 0, 0, 0, 0));
        vecs[7]  = mk_vec(4'b0000, 4'b0001, 0, 0, 0, mk_out(4'b0100, 2, 1, 0, 0, 0, 0, 0));
        vecs[8]  = mk_vec(4'b0000, 4'b0100, 0, 0, 0, mk_out(4'b0100, 2, 1, 0, 0, 0, 1, 0));
        vecs[9]  = mk_vec(4'b0000, 4'b0000, 0, 0, 0, z);
        vecs[10] = mk_vec(4'b0001, 4'b0000, 0, 0, 0, mk_out(4'b0001, 0, 1, 0, 0, 0, 0, 0));
        vecs[11] = mk_vec(4'b0000, 4'b0000, 1, 0, 0, mk_out(4'b0001, 0, 1, 0, 1, 0, 0, 0));
        vecs[12] = mk_vec(4'b0000, 4'b0000, 0, 1, 0, mk_out(4'b0001, 0, 1, 0, 1, 0, 1, 1));
        vecs[13] = mk_vec(4'b0000, 4'b0000, 0, 0, 0, z);
        vecs[14] = mk_vec(4'b1000, 4'b0000, 0, 0, 0, mk_out(4'b1000, 3, 1, 0, 0, 0, 0, 0));
        vecs[15] = mk_vec(4'b0000, 4'b0000, 1, 1, 0, mk_out(4'b1000, 3, 1, 0, 0, 0, 1, 1));
        vecs[16] = mk_vec(4'b0000, 4'b0000, 0, 0, 0, z);

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].go, vecs[i].kill, vecs[i].get, vecs[i].put, vecs[i].endtx, 1'b0);
            check($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
        end

        // Round robin with all channels requesting continuously.
        for (int t = 0; t < 5; t++) begin
            step_chk("rr_grant", 4'b1111, '0, 0, 0, 0);
            check_int("rr_owner", int'(owner), t % NCH);
            step_chk("rr_done", 4'b1111, '0, 0, 0, 1);
            step_chk("rr_idle", 4'b1111, '0, 0, 0, 0);
        end

        // Beat limit: MAX_BEATS gets accepted, the next one overflows.
        step_chk("ovf_grant", 4'b0001, '0, 0, 0, 0);
        for (int i = 0; i < MAX_BEATS; i++) step_chk("ovf_get", '0, '0, 1, 0, 0);
        check_int("ovf_full", int'(beats), MAX_BEATS);
        step_chk("ovf_abort", '0, '0, 1, 0, 0);
        check_int("ovf_err", abort ? int'(err) : -1, 2);
        step_chk("ovf_idle", '0, '0, 0, 0, 0);

        // Idle timeout.
        step_chk("tmo_grant", 4'b0100, '0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) step_chk("tmo_wait", '0, '0, 0, 0, 0);
        check_int("tmo_err", abort ? int'(err) : -1, 3);
        step_chk("tmo_idle", '0, '0, 0, 0, 0);

        // Reset mid-transaction: pointer returns to channel 0.
        step_chk("rst_grant", 4'b1001, '0, 0, 0, 0);
        check_int("rst_owner_pre", int'(owner), 3);
        for (int i = 0; i < 5; i++) step_chk("rst_put", 4'b1001, '0, 0, 1, 0);
        step(4'b1001, '0, 0, 0, 0, 1'b1);
        check("rst_mid", z, 1'b1);
        step_chk("rst_regrant", 4'b1001, '0, 0, 0, 0);
        check_int("rst_owner_post", int'(owner), 0);
        step_chk("rst_end", 4'b0000, '0, 0, 0, 1);
        step_chk("rst_end_idle", 4'b0000, '0, 0, 0, 0);

        // Randomized traffic against the reference model.
        rdir = 0;
        for (int n = 0; n < 1500; n++) begin
            rg  = ($urandom_range(0, 1) == 0) ? NCH'($urandom_range(1, 15)) : '0;
            rk  = ($urandom_range(0, 24) == 0) ? NCH'($urandom_range(1, 15)) : '0;
            if ($urandom_range(0, 19) == 0) rdir = ~rdir;
            sel = $urandom_range(0, 99);
            rgt = 0; rpt = 0;
            if (sel < 40) begin
                rgt = ~rdir; rpt = rdir;
            end else if (sel < 42) begin
                rgt = 1; rpt = 1;
            end
            ret = ($urandom_range(0, 11) == 0);
            rr  = ($urandom_range(0, 199) == 0);
            step(rg, rk, rgt, rpt, ret, rr);
            check("rand", model_out(), rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
